// File: rtl/csr_wb_pipe.sv
// Two-stage X->M->W pipeline that carries tohost CSR writes (CSRRW/CSRRWI) to writeback.
// Optional macro CSR_IMM_WRITE_EN enables CSRRWI; without it CSRRWI is treated as non-writing.
module csr_wb_pipe #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              x_valid,
  input  logic [31:0]       x_inst,
  input  logic [DATA_W-1:0] x_rs1_data,
  output logic              csr_we,
  output logic [DATA_W-1:0] wb_data,
  output logic              csr_busy,
  output logic [7:0]        csr_bad_cnt
);

  localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
  localparam logic [2:0]  F3_CSRRW   = 3'b001;
  localparam logic [2:0]  F3_CSRRWI  = 3'b101;
  localparam logic [11:0] CSR_TOHOST = 12'h51E;

  function automatic logic [7:0] sat_inc(input logic [7:0] val);
    sat_inc = (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  logic [6:0]        opcode_p0;
  logic [2:0]        funct3_p0;
  logic [11:0]       addr_p0;
  logic              is_csrrw_p0;
  logic              is_csrrwi_p0;
  logic              is_wr_p0;
  logic              we_p0;
  logic              bad_p0;
  logic              vld_p0;
  logic [DATA_W-1:0] zimm_p0;
  logic [DATA_W-1:0] data_p0;

  logic              vld_p1, we_p1, bad_p1;
  logic [DATA_W-1:0] data_p1;
  logic              vld_p2, we_p2, bad_p2;
  logic [DATA_W-1:0] data_p2;
  logic [7:0]        bad_cnt;

  // rd field and the W-stage bad flag are carried but not consumed by any output
  logic unused_bits;
  assign unused_bits = ^{x_inst[11:7], bad_p2};

  assign opcode_p0   = x_inst[6:0];
  assign funct3_p0   = x_inst[14:12];
  assign addr_p0     = x_inst[31:20];
  assign is_csrrw_p0 = (opcode_p0 == OPC_SYSTEM) && (funct3_p0 == F3_CSRRW);
`ifdef CSR_IMM_WRITE_EN
  assign is_csrrwi_p0 = (opcode_p0 == OPC_SYSTEM) && (funct3_p0 == F3_CSRRWI);
`else
  assign is_csrrwi_p0 = 1'b0;
`endif
  assign is_wr_p0 = is_csrrw_p0 | is_csrrwi_p0;
  assign we_p0    = is_wr_p0 & (addr_p0 == CSR_TOHOST);
  assign bad_p0   = is_wr_p0 & (addr_p0 != CSR_TOHOST);
  assign vld_p0   = x_valid & ~flush;
  assign zimm_p0  = {{(DATA_W-5){1'b0}}, x_inst[19:15]};
  // funct3[2] distinguishes the immediate form; harmless when CSRRWI is disabled since we_p0 is 0
  assign data_p0  = funct3_p0[2] ? zimm_p0 : x_rs1_data;

  // X -> M
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      we_p1   <= 1'b0;
      bad_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (!stall) begin
      vld_p1  <= vld_p0;
      we_p1   <= vld_p0 & we_p0;
      bad_p1  <= vld_p0 & bad_p0;
      data_p1 <= data_p0;
    end
  end

  // M -> W, plus the bad-address counter sampled on the same transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2  <= 1'b0;
      we_p2   <= 1'b0;
      bad_p2  <= 1'b0;
      data_p2 <= '0;
      bad_cnt <= 8'h00;
    end else if (!stall) begin
      vld_p2  <= vld_p1;
      we_p2   <= vld_p1 & we_p1;
      bad_p2  <= vld_p1 & bad_p1;
      data_p2 <= data_p1;
      if (vld_p1 && bad_p1)
        bad_cnt <= sat_inc(bad_cnt);
    end
  end

  assign csr_we      = we_p2;
  assign wb_data     = data_p2;
  assign csr_busy    = (vld_p1 & we_p1) | (vld_p2 & we_p2);
  assign csr_bad_cnt = bad_cnt;

endmodule

// File: tb/tb_csr_wb_pipe.sv
// Directed bench for csr_wb_pipe: expected writes queued at issue, monitor pops on each csr_we.
// Build with +define+CSR_IMM_WRITE_EN to exercise the CSRRWI-enabled configuration.
module tb_csr_wb_pipe;

  logic        clk = 1'b0;
  logic        reset, stall, flush, x_valid;
  logic [31:0] x_inst, x_rs1_data;
  logic        csr_we;
  logic [31:0] wb_data;
  logic        csr_busy;
  logic [7:0]  csr_bad_cnt;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   adv = 1'b0;

  localparam logic [31:0] I_RW     = 32'h51E09073;
  localparam logic [31:0] I_RWI    = 32'h51E2D073;
  localparam logic [31:0] I_RS     = 32'h51E0A073;
  localparam logic [31:0] I_BAD    = 32'h30009073;
  localparam logic [31:0] I_BADI   = 32'h3002D073;

`ifdef CSR_IMM_WRITE_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  csr_wb_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .x_valid    (x_valid),
    .x_inst     (x_inst),
    .x_rs1_data (x_rs1_data),
    .csr_we     (csr_we),
    .wb_data    (wb_data),
    .csr_busy   (csr_busy),
    .csr_bad_cnt(csr_bad_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    adv = !stall && !reset;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one expected entry per W-stage load that shows csr_we
  always @(negedge clk) begin
    if (!reset && csr_we === 1'b1 && adv) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_we: got csr_we=1 wb_data=%h expected csr_we=0 (cycle %0d)", wb_data, cyc);
      end else begin
        mon_e = q.pop_front();
        check("wb_data", wb_data, mon_e.data);
        check("we_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] rs1,
                       input logic fl, input logic st);
    x_valid    = v;
    x_inst     = inst;
    x_rs1_data = rs1;
    flush      = fl;
    stall      = st;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("rst_we", csr_we, 0);
    check("rst_data", wb_data, 0);
    check("rst_busy", csr_busy, 0);
    check("rst_cnt", csr_bad_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Basic CSRRW latency and busy window
    drive(1'b1, I_RW, 32'hDEADBEEF, 1'b0, 1'b0);
    q.push_back('{data: 32'hDEADBEEF, cyc: cyc + 2});
    @(negedge clk);
    x_valid = 1'b0;
    check("s1_busy_m", csr_busy, 1);
    check("s1_we_m", csr_we, 0);
    @(negedge clk);
    check("s1_busy_w", csr_busy, 1);
    check("s1_we_w", csr_we, 1);
    @(negedge clk);
    check("s1_we_after", csr_we, 0);
    check("s1_busy_after", csr_busy, 0);

    // Back-to-back writes
    drive(1'b1, I_RW, 32'h11111111, 1'b0, 1'b0);
    q.push_back('{data: 32'h11111111, cyc: cyc + 2});
    @(negedge clk);
    drive(1'b1, I_RW, 32'h22222222, 1'b0, 1'b0);
    q.push_back('{data: 32'h22222222, cyc: cyc + 2});
    @(negedge clk);
    x_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_we_idle", csr_we, 0);

    // CSRRWI
    drive(1'b1, I_RWI, 32'hFFFFFFFF, 1'b0, 1'b0);
    if (IMM_EN) q.push_back('{data: 32'h00000005, cyc: cyc + 2});
    @(negedge clk);
    x_valid = 1'b0;
    check("rwi_busy", csr_busy, IMM_EN ? 1 : 0);
    @(negedge clk);
    check("rwi_we", csr_we, IMM_EN ? 1 : 0);
    @(negedge clk);

    // Non-writing funct3 (CSRRS) to tohost
    drive(1'b1, I_RS, 32'hA5A5A5A5, 1'b0, 1'b0);
    @(negedge clk);
    x_valid = 1'b0;
    check("rs_busy", csr_busy, 0);
    @(negedge clk);
    check("rs_we", csr_we, 0);
    check("rs_cnt", csr_bad_cnt, 0);

    // Stall three cycles while in M
    drive(1'b1, I_RW, 32'hDEADBEEF, 1'b0, 1'b0);
    q.push_back('{data: 32'hDEADBEEF, cyc: cyc + 5});
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("stm_we", csr_we, 0);
      check("stm_busy", csr_busy, 1);
    end
    stall = 1'b0;
    @(negedge clk);
    check("stm_we_late", csr_we, 1);
    // Stall while in W, with a flush that must be ignored
    drive(1'b1, I_RW, 32'h77777777, 1'b1, 1'b1);
    repeat (2) begin
      @(negedge clk);
      check("stw_we_hold", csr_we, 1);
      check("stw_data_hold", wb_data, 32'hDEADBEEF);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("stw_we_drop", csr_we, 0);
    @(negedge clk);

    // Flush without stall kills; flush under stall is ignored and the write proceeds later
    drive(1'b1, I_RW, 32'h33333333, 1'b1, 1'b0);
    @(negedge clk);
    check("fl_busy", csr_busy, 0);
    drive(1'b1, I_RW, 32'h44444444, 1'b1, 1'b1);
    @(negedge clk);
    check("flst_busy", csr_busy, 0);
    drive(1'b1, I_RW, 32'h44444444, 1'b0, 1'b0);
    q.push_back('{data: 32'h44444444, cyc: cyc + 2});
    @(negedge clk);
    x_valid = 1'b0;
    check("flst_busy_m", csr_busy, 1);
    @(negedge clk);
    @(negedge clk);
    check("fl_we_idle", csr_we, 0);

    // Bad-address counting and saturation
    drive(1'b1, I_BAD, 32'h12345678, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    x_valid = 1'b0;
    check("bad_busy", csr_busy, 0);
    repeat (2) @(negedge clk);
    check("bad_cnt3", csr_bad_cnt, 8'd3);
    drive(1'b1, I_BADI, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    x_valid = 1'b0;
    @(negedge clk);
    check("badi_cnt", csr_bad_cnt, IMM_EN ? 8'd4 : 8'd3);
    drive(1'b1, I_BAD, 32'h12345678, 1'b0, 1'b0);
    repeat (300) @(negedge clk);
    x_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("bad_sat", csr_bad_cnt, 8'hFF);
    x_valid = 1'b1;
    repeat (5) @(negedge clk);
    x_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("bad_sat_hold", csr_bad_cnt, 8'hFF);
    check("bad_we", csr_we, 0);

    // Reset mid-operation: one write in W, another in M
    drive(1'b1, I_RW, 32'h55555555, 1'b0, 1'b0);
    q.push_back('{data: 32'h55555555, cyc: cyc + 2});
    @(negedge clk);
    drive(1'b1, I_RW, 32'h66666666, 1'b0, 1'b0);
    @(negedge clk);
    x_valid = 1'b0;
    check("pre_rst_data", wb_data, 32'h55555555);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_we", csr_we, 0);
    check("mid_rst_data", wb_data, 0);
    check("mid_rst_busy", csr_busy, 0);
    check("mid_rst_cnt", csr_bad_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_we", csr_we, 0);
    check("post_rst_busy", csr_busy, 0);

    check("pending_expected", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
